// File: rtl/uart_tx_engine_pkg.sv
// Shared UART definitions used by the baud decoder,
// transmit engine and receive engine.
package uart_tx_engine_pkg;

    localparam int   UART_FRAME_BITS = 11;
    localparam int   UART_CNT_W      = 19;
    localparam logic UART_IDLE_LINE  = 1'b1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } tx_state_e;

endpackage

// File: rtl/uart_tx_engine_bit_time_counter.sv
// Loadable bit-period counter; btu pulses on the last clock of
// each bit period while enabled, then the count wraps to zero.
module bit_time_counter
    import uart_tx_engine_pkg::*;
#(
    parameter int W = UART_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         btu
);

    logic [W-1:0] r_cnt;

    assign btu = enable && (r_cnt == limit);

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            r_cnt <= '0;
        end else if (btu) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART serial transmit engine: one 11-bit-time frame per load,
// start bit, 7/8 data bits LSB first, optional parity, stop ones.
module uart_tx_engine
    import uart_tx_engine_pkg::*;
#(
    parameter int FRAME_BITS = UART_FRAME_BITS,
    parameter int CNT_W      = UART_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] baud_count,
    input  logic             load,
    input  logic [7:0]       out_port,
    input  logic             eight,
    input  logic             pen,
    input  logic             ohel,
    output logic             tx,
    output logic             tx_rdy
);

    tx_state_e             r_state;
    logic [CNT_W-1:0]      r_limit;
    logic [FRAME_BITS-1:0] r_sr;
    logic [3:0]            r_bitcnt;
    logic                  r_rdy;
    logic                  w_btu;
    logic                  w_b8;
    logic                  w_b9;
    logic [FRAME_BITS-1:0] w_frame;

    always_comb begin
        w_b8 = 1'b1;
        w_b9 = 1'b1;
        if (eight) begin
            w_b8 = out_port[7];
            if (pen) w_b9 = (^out_port) ^ ohel;
        end else if (pen) begin
            w_b8 = (^out_port[6:0]) ^ ohel;
        end
        w_frame = {UART_IDLE_LINE, w_b9, w_b8, out_port[6:0], 1'b0};
    end

    bit_time_counter #(.W(CNT_W)) u_btc (
        .clk    (clk),
        .reset  (reset),
        .enable (r_state == S_SHIFT),
        .limit  (r_limit),
        .btu    (w_btu)
    );

    // The shift register itself drives the line, so tx is registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_limit  <= '0;
            r_sr     <= {FRAME_BITS{UART_IDLE_LINE}};
            r_bitcnt <= '0;
            r_rdy    <= 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_state  <= S_SHIFT;
                        r_limit  <= baud_count;
                        r_sr     <= w_frame;
                        r_bitcnt <= '0;
                        r_rdy    <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (w_btu) begin
                        r_sr <= {UART_IDLE_LINE, r_sr[FRAME_BITS-1:1]};
                        if (r_bitcnt == 4'(FRAME_BITS - 1)) begin
                            r_state  <= S_IDLE;
                            r_bitcnt <= '0;
                            r_rdy    <= 1'b1;
                        end else begin
                            r_bitcnt <= r_bitcnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx     = r_sr[0];
    assign tx_rdy = r_rdy;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: expected frames queued
// at load time, checked bit-by-bit by a negedge line monitor.
module tb_uart_tx_engine;

    typedef struct {
        logic [10:0] bits;
        int          bc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [18:0] baud_count;
    logic        load;
    logic [7:0]  out_port;
    logic        eight;
    logic        pen;
    logic        ohel;
    logic        tx;
    logic        tx_rdy;

    int   tests;
    int   fails;
    exp_t exp_q[$];
    logic samples[$];
    bit   in_frame;
    bit   aborted;
    int   idle_cnt;
    int   last_gap;
    int   frames_seen;

    uart_tx_engine dut (
        .clk        (clk),
        .reset      (reset),
        .baud_count (baud_count),
        .load       (load),
        .out_port   (out_port),
        .eight      (eight),
        .pen        (pen),
        .ohel       (ohel),
        .tx         (tx),
        .tx_rdy     (tx_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] model(input logic [7:0] d,
                                          input logic e,
                                          input logic p,
                                          input logic o);
        logic [10:0] f;
        f       = '1;
        f[0]    = 1'b0;
        f[7:1]  = d[6:0];
        if (e) begin
            f[8] = d[7];
            if (p) f[9] = (^d) ^ o;
        end else if (p) begin
            f[8] = (^d[6:0]) ^ o;
        end
        return f;
    endfunction

    // Line monitor: collects one sample per clock while tx_rdy is low.
    always @(negedge clk) begin
        if (in_frame) begin
            if (reset) aborted = 1'b1;
            if (tx_rdy) begin
                in_frame = 1'b0;
                idle_cnt = 1;
                if (!aborted) begin
                    frames_seen++;
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_frame: got %0d clocks, required none",
                                 samples.size());
                    end else begin
                        exp_t e;
                        int   bad;
                        int   per;
                        e   = exp_q.pop_front();
                        per = e.bc + 1;
                        if (samples.size() !== 11 * per) begin
                            fails++;
                            $display("FAIL frame_len: got %0d clocks, required %0d",
                                     samples.size(), 11 * per);
                        end else begin
                            bad = 0;
                            for (int i = 0; i < 11; i++)
                                for (int j = 0; j < per; j++)
                                    if (samples[i*per+j] !== e.bits[i]) bad++;
                            tests++;
                            if (bad != 0) begin
                                fails++;
                                $display("FAIL frame_bits: %0d bad samples, required bits %b (LSB first)",
                                         bad, e.bits);
                            end
                        end
                        tests++;
                        if (tx !== 1'b1) begin
                            fails++;
                            $display("FAIL stop_at_rdy: tx=%b required 1", tx);
                        end
                    end
                end
            end else begin
                samples.push_back(tx);
            end
        end else if (!tx_rdy && !reset) begin
            in_frame = 1'b1;
            aborted  = 1'b0;
            last_gap = idle_cnt;
            samples.delete();
            samples.push_back(tx);
        end else begin
            idle_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load(input logic [7:0] d, input logic e,
                              input logic p, input logic o,
                              input int bc);
        out_port   = d;
        eight      = e;
        pen        = p;
        ohel       = o;
        baud_count = 19'(bc);
        load       = 1'b1;
        step();
        load       = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (tx_rdy) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        step();
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        tests++;
        if (tx !== 1'b1) begin
            fails++;
            $display("FAIL reset_tx: got %b required 1", tx);
        end
        tests++;
        if (tx_rdy !== 1'b1) begin
            fails++;
            $display("FAIL reset_rdy: got %b required 1", tx_rdy);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_8bit_even();
        bit ok;
        exp_q.push_back('{11'b10101001010, 9});
        pulse_load(8'hA5, 1'b1, 1'b1, 1'b0, 9);
        tests++;
        if (tx !== 1'b0 || tx_rdy !== 1'b0) begin
            fails++;
            $display("FAIL load_latency: tx=%b rdy=%b required 0 0", tx, tx_rdy);
        end
        wait_idle(200, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL timeout_8e: tx_rdy=%b required 1", tx_rdy);
        end
    endtask

    task automatic test_7bit_nopar();
        bit ok;
        exp_q.push_back('{11'b11110000010, 9});
        pulse_load(8'hC1, 1'b0, 1'b0, 1'b0, 9);
        wait_idle(200, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL timeout_7n: tx_rdy=%b required 1", tx_rdy);
        end
    endtask

    task automatic test_7bit_odd();
        bit ok;
        exp_q.push_back('{11'b11100000110, 9});
        pulse_load(8'h03, 1'b0, 1'b1, 1'b1, 9);
        wait_idle(200, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL timeout_7o: tx_rdy=%b required 1", tx_rdy);
        end
    endtask

    task automatic test_held_inputs();
        bit ok;
        int n;
        exp_q.push_back('{model(8'h5A, 1'b1, 1'b0, 1'b0), 9});
        pulse_load(8'h5A, 1'b1, 1'b0, 1'b0, 9);
        repeat (25) step();
        pulse_load(8'hFF, 1'b0, 1'b1, 1'b1, 3);
        wait_idle(200, ok);
        n = frames_seen;
        repeat (60) step();
        tests++;
        if (!ok || frames_seen !== n || tx_rdy !== 1'b1) begin
            fails++;
            $display("FAIL held_no_queue: ok=%b frames=%0d required %0d rdy=%b",
                     ok, frames_seen, n, tx_rdy);
        end
        exp_q.push_back('{model(8'h96, 1'b1, 1'b1, 1'b1), 3});
        pulse_load(8'h96, 1'b1, 1'b1, 1'b1, 3);
        wait_idle(100, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL timeout_held: tx_rdy=%b required 1", tx_rdy);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        pulse_load(8'h00, 1'b1, 1'b0, 1'b0, 9);
        repeat (54) step();
        reset = 1'b1;
        step();
        tests++;
        if (tx !== 1'b1 || tx_rdy !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid: tx=%b rdy=%b required 1 1", tx, tx_rdy);
        end
        reset = 1'b0;
        repeat (3) step();
        exp_q.push_back('{model(8'h3C, 1'b0, 1'b1, 1'b0), 9});
        pulse_load(8'h3C, 1'b0, 1'b1, 1'b0, 9);
        wait_idle(200, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL timeout_rst: tx_rdy=%b required 1", tx_rdy);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        exp_q.push_back('{model(8'h55, 1'b1, 1'b1, 1'b0), 867});
        exp_q.push_back('{model(8'hE7, 1'b1, 1'b0, 1'b0), 867});
        pulse_load(8'h55, 1'b1, 1'b1, 1'b0, 867);
        ok = 1'b0;
        for (int i = 0; i < 12000; i++) begin
            if (tx_rdy) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        pulse_load(8'hE7, 1'b1, 1'b0, 1'b0, 867);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL timeout_b2b_1: tx_rdy=%b required 1", tx_rdy);
        end
        wait_idle(12000, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL timeout_b2b_2: tx_rdy=%b required 1", tx_rdy);
        end
        tests++;
        if (last_gap !== 1) begin
            fails++;
            $display("FAIL b2b_gap: got %0d idle clocks required 1", last_gap);
        end
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        in_frame    = 1'b0;
        aborted     = 1'b0;
        idle_cnt    = 0;
        last_gap    = 0;
        frames_seen = 0;
        reset       = 1'b1;
        load        = 1'b0;
        baud_count  = '0;
        out_port    = '0;
        eight       = 1'b0;
        pen         = 1'b0;
        ohel        = 1'b0;
        test_reset();
        test_8bit_even();
        test_7bit_nopar();
        test_7bit_odd();
        test_held_inputs();
        test_reset_mid();
        test_back_to_back();
        tests++;
        if (exp_q.size() !== 0) begin
            fails++;
            $display("FAIL missing_frames: %0d left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
